// File: rtl/min_max_pkg.sv
// Shared definitions for the min/max finder front end: FSM encodings,
// default geometry and the two-way round-robin pick.
package min_max_pkg;

  localparam int DATA_W_DEF  = 8;
  localparam int DEPTH_DEF   = 16;
  localparam int TIMEOUT_DEF = 64;

  typedef enum logic [4:0] {
    S_IDLE  = 5'b00001,
    S_FILL  = 5'b00010,
    S_START = 5'b00100,
    S_BUSY  = 5'b01000,
    S_RESP  = 5'b10000
  } state_e;

  // ptr selects the winner only when both clients request.
  function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic ptr);
    logic [1:0] g;
    if (req == 2'b11) g = ptr ? 2'b10 : 2'b01;
    else              g = req;
    return g;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-client round-robin grant. The pointer moves to the client that was not
// just served whenever a job completes or aborts.
module rr_arb2
  import min_max_pkg::*;
(
  input  logic       Clk,
  input  logic       Reset,
  input  logic [1:0] i_req,
  input  logic       i_adv,
  input  logic       i_served,
  output logic [1:0] o_gnt
);

  logic r_ptr;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)      r_ptr <= 1'b0;
    else if (i_adv) r_ptr <= ~i_served;
  end

  assign o_gnt = rr_pick(i_req, r_ptr);

endmodule

// File: rtl/min_max_arbiter.sv
// Shares one min_max_finder engine between two clients: grant, stream the
// job into the engine array, start it, and hand the result back.
module min_max_arbiter
  import min_max_pkg::*;
#(
  parameter  int DATA_W  = DATA_W_DEF,
  parameter  int DEPTH   = DEPTH_DEF,
  parameter  int TIMEOUT = TIMEOUT_DEF,
  localparam int AW      = $clog2(DEPTH),
  localparam int TW      = $clog2(TIMEOUT)
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [1:0]        Req,
  output logic [1:0]        Gnt,
  input  logic [DATA_W-1:0] DIn,
  input  logic              DValid,
  output logic              MemWe,
  output logic [AW-1:0]     MemAddr,
  output logic [DATA_W-1:0] MemData,
  output logic              EngStart,
  input  logic              EngDone,
  input  logic [DATA_W-1:0] EngMax,
  input  logic [DATA_W-1:0] EngMin,
  output logic              RValid,
  output logic              RId,
  output logic [DATA_W-1:0] RMax,
  output logic [DATA_W-1:0] RMin,
  output logic              RErr,
  input  logic              RAck,
  output logic              Busy
);

  state_e            r_state, w_state_nx;
  logic [1:0]        r_gnt, w_gnt_nx;
  logic              r_we, w_we_nx;
  logic [AW-1:0]     r_addr, w_addr_nx;
  logic [DATA_W-1:0] r_data, w_data_nx;
  logic              r_start, w_start_nx;
  logic              r_rvalid, w_rvalid_nx;
  logic              r_rid, w_rid_nx;
  logic [DATA_W-1:0] r_rmax, w_rmax_nx;
  logic [DATA_W-1:0] r_rmin, w_rmin_nx;
  logic              r_rerr, w_rerr_nx;
  logic [AW-1:0]     r_cnt, w_cnt_nx;
  logic [TW-1:0]     r_timer, w_timer_nx;
  logic [1:0]        w_arb_gnt;
  logic              w_adv;

  rr_arb2 u_arb (
    .Clk      (Clk),
    .Reset    (Reset),
    .i_req    (Req),
    .i_adv    (w_adv),
    .i_served (r_gnt[1]),
    .o_gnt    (w_arb_gnt)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state  <= S_IDLE;
      r_gnt    <= '0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_data   <= '0;
      r_start  <= 1'b0;
      r_rvalid <= 1'b0;
      r_rid    <= 1'b0;
      r_rmax   <= '0;
      r_rmin   <= '0;
      r_rerr   <= 1'b0;
      r_cnt    <= '0;
      r_timer  <= '0;
    end else begin
      r_state  <= w_state_nx;
      r_gnt    <= w_gnt_nx;
      r_we     <= w_we_nx;
      r_addr   <= w_addr_nx;
      r_data   <= w_data_nx;
      r_start  <= w_start_nx;
      r_rvalid <= w_rvalid_nx;
      r_rid    <= w_rid_nx;
      r_rmax   <= w_rmax_nx;
      r_rmin   <= w_rmin_nx;
      r_rerr   <= w_rerr_nx;
      r_cnt    <= w_cnt_nx;
      r_timer  <= w_timer_nx;
    end
  end

  always_comb begin
    w_state_nx  = r_state;
    w_gnt_nx    = r_gnt;
    w_we_nx     = 1'b0;
    w_addr_nx   = r_addr;
    w_data_nx   = r_data;
    w_start_nx  = 1'b0;
    w_rvalid_nx = r_rvalid;
    w_rid_nx    = r_rid;
    w_rmax_nx   = r_rmax;
    w_rmin_nx   = r_rmin;
    w_rerr_nx   = r_rerr;
    w_cnt_nx    = r_cnt;
    w_timer_nx  = r_timer;
    w_adv       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (|Req) begin
          w_gnt_nx   = w_arb_gnt;
          w_cnt_nx   = '0;
          w_state_nx = S_FILL;
        end
      end
      S_FILL: begin
        // Abort takes precedence over a beat arriving in the same cycle.
        if (!(|(Req & r_gnt))) begin
          w_gnt_nx   = '0;
          w_adv      = 1'b1;
          w_state_nx = S_IDLE;
        end else if (DValid) begin
          w_we_nx   = 1'b1;
          w_addr_nx = r_cnt;
          w_data_nx = DIn;
          w_cnt_nx  = r_cnt + 1'b1;
          if (r_cnt == AW'(DEPTH - 1)) begin
            w_start_nx = 1'b1;
            w_state_nx = S_START;
          end
        end
      end
      S_START: begin
        w_timer_nx = '0;
        w_state_nx = S_BUSY;
      end
      S_BUSY: begin
        if (EngDone) begin
          w_rmax_nx   = EngMax;
          w_rmin_nx   = EngMin;
          w_rerr_nx   = 1'b0;
          w_rvalid_nx = 1'b1;
          w_rid_nx    = r_gnt[1];
          w_state_nx  = S_RESP;
        end else if (r_timer == TW'(TIMEOUT - 1)) begin
          w_rmax_nx   = '0;
          w_rmin_nx   = '0;
          w_rerr_nx   = 1'b1;
          w_rvalid_nx = 1'b1;
          w_rid_nx    = r_gnt[1];
          w_state_nx  = S_RESP;
        end else begin
          w_timer_nx = r_timer + 1'b1;
        end
      end
      S_RESP: begin
        if (RAck) begin
          w_rvalid_nx = 1'b0;
          w_gnt_nx    = '0;
          w_adv       = 1'b1;
          w_state_nx  = S_IDLE;
        end
      end
      default: begin
        w_gnt_nx    = '0;
        w_rvalid_nx = 1'b0;
        w_state_nx  = S_IDLE;
      end
    endcase
  end

  assign Gnt      = r_gnt;
  assign MemWe    = r_we;
  assign MemAddr  = r_addr;
  assign MemData  = r_data;
  assign EngStart = r_start;
  assign RValid   = r_rvalid;
  assign RId      = r_rid;
  assign RMax     = r_rmax;
  assign RMin     = r_rmin;
  assign RErr     = r_rerr;
  assign Busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_min_max_arbiter.sv
// Bench for min_max_arbiter: two-client driver, behavioural engine model on
// the shared array, and scoreboards for array writes and results.
module tb_min_max_arbiter;

  localparam int LAT = 5;

  logic            Clk = 1'b0;
  logic            Reset = 1'b1;
  logic [1:0]      Req = '0;
  logic [1:0]      Gnt;
  logic [7:0]      DIn = '0;
  logic            DValid = 1'b0;
  logic            MemWe;
  logic [3:0]      MemAddr;
  logic [7:0]      MemData;
  logic            EngStart;
  logic            EngDone = 1'b0;
  logic [7:0]      EngMax = '0;
  logic [7:0]      EngMin = '0;
  logic            RValid, RId, RErr, Busy;
  logic [7:0]      RMax, RMin;
  logic            RAck = 1'b0;

  min_max_arbiter dut (
    .Clk(Clk), .Reset(Reset), .Req(Req), .Gnt(Gnt), .DIn(DIn), .DValid(DValid),
    .MemWe(MemWe), .MemAddr(MemAddr), .MemData(MemData), .EngStart(EngStart),
    .EngDone(EngDone), .EngMax(EngMax), .EngMin(EngMin), .RValid(RValid),
    .RId(RId), .RMax(RMax), .RMin(RMin), .RErr(RErr), .RAck(RAck), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  int n_tot = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct packed { logic id; logic [7:0] mx; logic [7:0] mn; logic err; } res_t;
  typedef struct packed { logic [3:0] a; logic [7:0] d; } wr_t;
  res_t rq[$];
  wr_t  wq[$];

  logic [7:0] shmem [16];
  int  eng_cnt   = 0;
  bit  eng_hang  = 1'b0;
  int  n_start   = 0;
  int  exp_start = 0;

  // Engine model: records array writes, answers LAT cycles after Start.
  initial forever begin
    wr_t w;
    logic [7:0] mx, mn;
    @(negedge Clk);
    EngDone = 1'b0;
    if (Reset) eng_cnt = 0;
    else begin
      if (MemWe) begin
        shmem[MemAddr] = MemData;
        if (wq.size() == 0) chk("wr_extra", 1, 0);
        else begin
          w = wq.pop_front();
          chk("wr_addr", MemAddr, w.a);
          chk("wr_data", MemData, w.d);
        end
      end
      if (eng_cnt > 0) begin
        eng_cnt--;
        if (eng_cnt == 0 && !eng_hang) begin
          mx = 8'h00; mn = 8'hff;
          for (int j = 0; j < 16; j++) begin
            if (shmem[j] > mx) mx = shmem[j];
            if (shmem[j] < mn) mn = shmem[j];
          end
          EngMax = mx; EngMin = mn; EngDone = 1'b1;
        end
      end
      if (EngStart) begin
        n_start++;
        eng_cnt = LAT;
      end
    end
  end

  task automatic rst_chk();
    chk("rst_gnt", Gnt, 0);       chk("rst_we", MemWe, 0);
    chk("rst_addr", MemAddr, 0);  chk("rst_data", MemData, 0);
    chk("rst_start", EngStart, 0); chk("rst_rvld", RValid, 0);
    chk("rst_rid", RId, 0);       chk("rst_rmax", RMax, 0);
    chk("rst_rmin", RMin, 0);     chk("rst_rerr", RErr, 0);
    chk("rst_busy", Busy, 0);
  endtask

  function automatic logic [15:0][7:0] rnd_data();
    logic [15:0][7:0] d;
    for (int j = 0; j < 16; j++) d[j] = 8'($urandom);
    return d;
  endfunction

  // Runs one job for client c; caller raises Req[c] and is at a negedge.
  task automatic serve(input int c, input logic [15:0][7:0] d, input logic [15:0] gap,
                       input bit hang, input int drop_at, input bit keep, input bit rst_busy);
    int   cyc;
    logic [7:0] mx, mn;
    res_t e;
    eng_hang = hang;
    for (int i = 0; i < 300 && !(|Gnt); i++) @(negedge Clk);
    chk("gnt", Gnt, 32'(2'b01 << c));
    if (Gnt != 2'(2'b01 << c)) return;
    mx = 8'h00; mn = 8'hff;
    for (int b = 0; b < 16; b++) begin
      if (gap[b]) begin
        DValid = 1'b0; DIn = 8'($urandom);
        @(negedge Clk);
      end
      if (b == drop_at) begin
        Req[c] = 1'b0; DValid = 1'b0;
        @(negedge Clk);
        chk("abort_gnt", Gnt, 0);
        chk("abort_busy", Busy, 0);
        return;
      end
      DIn = d[b]; DValid = 1'b1;
      wq.push_back({4'(b), d[b]});
      if (d[b] > mx) mx = d[b];
      if (d[b] < mn) mn = d[b];
      @(negedge Clk);
    end
    // Junk beats outside FILL must not reach the array.
    DValid = 1'b1; DIn = 8'($urandom);
    chk("start", EngStart, 1);
    chk("last_addr", MemAddr, 15);
    exp_start++;
    if (rst_busy) begin
      eng_hang = 1'b1;
      repeat (10) @(negedge Clk);
      DValid = 1'b0;
      chk("busy_pre", Busy, 1);
      #2 Reset = 1'b1;
      #1 rst_chk();
      @(negedge Clk);
      Reset = 1'b0; Req = '0; eng_hang = 1'b0;
      return;
    end
    e.id = c[0]; e.err = hang;
    e.mx = hang ? 8'h00 : mx;
    e.mn = hang ? 8'h00 : mn;
    rq.push_back(e);
    cyc = 0;
    while (!RValid && cyc < 300) begin
      @(negedge Clk);
      cyc++;
    end
    DValid = 1'b0;
    chk("lat", cyc, hang ? 65 : 6);
    if (rq.size() == 0) chk("rq_empty", 1, 0);
    else begin
      e = rq.pop_front();
      chk("rid", RId, e.id);   chk("rmax", RMax, e.mx);
      chk("rmin", RMin, e.mn); chk("rerr", RErr, e.err);
    end
    @(negedge Clk);
    chk("hold_vld", RValid, 1);
    chk("hold_max", RMax, e.mx);
    RAck = 1'b1;
    @(negedge Clk);
    RAck = 1'b0; Req[c] = keep;
    chk("ack_vld", RValid, 0);
    chk("ack_gnt", Gnt, 0);
  endtask

  localparam logic [15:0][7:0] D1 = {8'd1, 8'd200, 8'd64, 8'd77, 8'd12, 8'd99, 8'd33, 8'd60,
                                     8'd150, 8'd7, 8'd88, 8'd42, 8'd17, 8'd3, 8'd9, 8'd5};

  initial begin
    repeat (2) @(negedge Clk);
    rst_chk();
    Reset = 1'b0;
    // single request
    Req = 2'b01;
    serve(0, D1, 16'h0, 0, 16, 0, 0);
    // simultaneous requests straight after reset
    Reset = 1'b1; @(negedge Clk); Reset = 1'b0;
    Req = 2'b11;
    serve(0, rnd_data(), 16'h0, 0, 16, 0, 0);
    @(negedge Clk);
    chk("t2_gnt1", Gnt, 2'b10);
    serve(1, rnd_data(), 16'h0, 0, 16, 0, 0);
    // client 0 re-requests back to back: 0,1,0
    Req = 2'b11;
    serve(0, rnd_data(), 16'h0, 0, 16, 1, 0);
    serve(1, rnd_data(), 16'h0, 0, 16, 0, 0);
    serve(0, rnd_data(), 16'h0, 0, 16, 0, 0);
    // gaps in the fill
    Req = 2'b01;
    serve(0, rnd_data(), 16'h1108, 0, 16, 0, 0);
    // engine never finishes
    Req = 2'b10;
    serve(1, rnd_data(), 16'h0, 1, 16, 0, 0);
    // abort at beat 7, pointer must hand the engine to client 1
    Req = 2'b11;
    serve(0, rnd_data(), 16'h0, 0, 7, 0, 0);
    Req[0] = 1'b1;
    @(negedge Clk);
    chk("abort_next", Gnt, 2'b10);
    serve(1, rnd_data(), 16'h0, 0, 16, 0, 0);
    serve(0, rnd_data(), 16'h0, 0, 16, 0, 0);
    // reset in BUSY
    Req = 2'b01;
    serve(0, rnd_data(), 16'h0, 0, 16, 0, 1);
    repeat (2) @(negedge Clk);
    chk("starts", n_start, exp_start);
    chk("wq_left", wq.size(), 0);
    chk("rq_left", rq.size(), 0);
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
